ysyx_22050854_divider: RTL

Iterative radix-2 integer divider for the RV64M divide/remainder instructions (DIV, DIVU, REM, REMU and their W forms). Sits beside the single-cycle ALU in the execute stage. The ALU covers add/shift/sub in one cycle; this block takes one operand pair over a valid/ready request handshake and returns one 64-bit result over a valid/ready response handshake. Its multi-cycle latency stalls the pipeline through in_ready and out_valid.

---
 rtl/ysyx_22050854_divider.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050854_divider.sv
// ysyx_22050854_divider
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// A request is taken over a valid/ready handshake. The quotient and remainder
// are computed one bit per cycle. The selected result is returned over a second
// valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid                in_ready   request accepted (IDLE only)
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   is_word    W form: 32-bit operands, result sign-extended from bit 31
//   src1/src2  dividend / divisor
//   flush      abandon any in-flight operation
//   out_valid  result valid                 out_ready  consumer accepts result
//   result     quotient or remainder
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | shift-subtract iterations, counter runs 63 down to 0
// DONE  | result held until consumed (special cases spend one finalize cycle here)
module ysyx_22050854_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic            word_q;
  logic            qneg_q, rneg_q;
  logic [XLEN-1:0] dvd_q;   // dividend, becomes the quotient as bits shift in
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [5:0]      cnt_q;
  logic            res_vld_q;
  logic [XLEN-1:0] result_q;

  // Operand preparation
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic            sgn, a_neg, b_neg, div_zero, ovf, special;

  always_comb begin
    sgn = ~op[0];
    if (is_word) begin
      a_ext = sgn ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
      b_ext = sgn ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext = src1;
      b_ext = src2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = sgn & a_ext[XLEN-1];
    b_neg    = sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn && (b_ext == '1) && (a_ext == min_neg);
    special  = div_zero | ovf;
  end

  // One restoring iteration. The partial remainder keeps an extra top bit so
  // the compare is exact even for divisors with bit XLEN-1 set.
  logic [XLEN:0]   partial, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, dvd_nx;

  always_comb begin
    partial = {rem_q, dvd_q[XLEN-1]};
    diff    = partial - {1'b0, dvs_q};
    ge      = (partial >= {1'b0, dvs_q});
    rem_nx  = ge ? diff[XLEN-1:0] : partial[XLEN-1:0];
    dvd_nx  = {dvd_q[XLEN-2:0], ge};
  end

  // Sign fix-up and selection. On the last CALC cycle the freshly computed
  // values are used so the result lands in the same edge that enters DONE.
  logic [XLEN-1:0] fin_q, fin_r, fix_q, fix_r, sel, fin_res;

  always_comb begin
    fin_q   = (state_q == CALC) ? dvd_nx : dvd_q;
    fin_r   = (state_q == CALC) ? rem_nx : rem_q;
    fix_q   = qneg_q ? -fin_q : fin_q;
    fix_r   = rneg_q ? -fin_r : fin_r;
    sel     = op_q[1] ? fix_r : fix_q;
    fin_res = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == 6'd0) state_d = DONE;
      DONE:    if (res_vld_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      word_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      res_vld_q <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      res_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            word_q    <= is_word;
            dvs_q     <= b_mag;
            cnt_q     <= 6'd63;
            res_vld_q <= 1'b0;
            if (div_zero) begin
              dvd_q  <= '1;
              rem_q  <= a_ext;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
            end else if (ovf) begin
              dvd_q  <= a_ext;
              rem_q  <= '0;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
            end else begin
              dvd_q  <= a_mag;
              rem_q  <= '0;
              qneg_q <= a_neg ^ b_neg;
              rneg_q <= a_neg;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            result_q  <= fin_res;
            res_vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (!res_vld_q) begin
            result_q  <= fin_res;
            res_vld_q <= 1'b1;
          end else if (out_ready) begin
            res_vld_q <= 1'b0;
          end
        end
        default: res_vld_q <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE) && res_vld_q;
  assign result    = result_q;

endmodule
